// File: rtl/mips_pkg.sv
// Shared writeback-stage definitions: register-zero address, default widths, writeback source select.
// Pure type/constant package; no logic, no latency, no backpressure.
package mips_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Encoding matches the MEM/WB memToReg bit.
    typedef enum logic {
        WB_ALU = 1'b0,
        WB_MEM = 1'b1
    } wb_sel_t;
endpackage

// File: rtl/wb_mux.sv
// Writeback source select between load data and ALU result; combinational, zero latency.
// No handshake or backpressure: the output tracks the inputs every cycle.
module wb_mux
    import mips_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              i_sel,
    input  logic [DATA_W-1:0] i_ram_data,
    input  logic [DATA_W-1:0] i_alu_result,
    output logic [DATA_W-1:0] o_wb_data
);
    wb_sel_t w_sel;

    assign w_sel     = wb_sel_t'(i_sel);
    assign o_wb_data = (w_sel == WB_MEM) ? i_ram_data : i_alu_result;
endmodule

// File: rtl/wb_regfile.sv
// Writeback commit into a 2**ADDR_W x DATA_W register file with two combinational, write-through read ports.
// Write latency 1 cycle; reads 0 cycles; accepts one writeback per cycle, never stalls.
module wb_regfile
    import mips_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] i_ram_data,
    input  logic [DATA_W-1:0] i_alu_result,
    input  logic [ADDR_W-1:0] i_inst_mux_br_write_address,
    input  logic              i_regWrite,
    input  logic              i_memToReg,
    input  logic [ADDR_W-1:0] i_read_addr1,
    input  logic [ADDR_W-1:0] i_read_addr2,
    output logic [DATA_W-1:0] o_read_data1,
    output logic [DATA_W-1:0] o_read_data2,
    output logic [DATA_W-1:0] o_wb_data,
    output logic [CNT_W-1:0]  o_wb_count
);
    localparam int NREGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] r_regs [NREGS];
    logic [CNT_W-1:0]  r_wb_count;
    logic [DATA_W-1:0] w_wb_data;
    logic              w_commit;

    wb_mux #(.DATA_W(DATA_W)) u_wb_mux (
        .i_sel        (i_memToReg),
        .i_ram_data   (i_ram_data),
        .i_alu_result (i_alu_result),
        .o_wb_data    (w_wb_data)
    );

    // Reset suppresses the commit, which also disables the read bypass.
    assign w_commit = !rst && i_regWrite && (i_inst_mux_br_write_address != ZERO_ADDR);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
            r_wb_count <= '0;
        end else if (w_commit) begin
            r_regs[i_inst_mux_br_write_address] <= w_wb_data;
            r_wb_count                          <= r_wb_count + 1'b1;
        end
    end

    always_comb begin
        o_read_data1 = r_regs[i_read_addr1];
        if (i_read_addr1 == ZERO_ADDR) begin
            o_read_data1 = '0;
        end else if (w_commit && (i_read_addr1 == i_inst_mux_br_write_address)) begin
            o_read_data1 = w_wb_data;
        end
    end

    always_comb begin
        o_read_data2 = r_regs[i_read_addr2];
        if (i_read_addr2 == ZERO_ADDR) begin
            o_read_data2 = '0;
        end else if (w_commit && (i_read_addr2 == i_inst_mux_br_write_address)) begin
            o_read_data2 = w_wb_data;
        end
    end

    assign o_wb_data  = w_wb_data;
    assign o_wb_count = r_wb_count;
endmodule

// File: tb/tb_wb_regfile.sv
// Directed and random stimulus for wb_regfile against an array/counter reference model.
// A narrow counter instance lets the wrap from all-ones to zero be reached by real writes.
module tb_wb_regfile;
    localparam int CW = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i_ram_data, i_alu_result;
    logic [4:0]  i_wa, i_ra1, i_ra2;
    logic        i_we, i_mtr;
    logic [31:0] o_rd1, o_rd2, o_wb_data;
    logic [CW-1:0] o_wb_count;

    int errors = 0;
    int checks = 0;

    logic [31:0] m_regs [32];
    int unsigned m_cnt;

    always #5 clk = ~clk;

    wb_regfile #(.DATA_W(32), .ADDR_W(5), .CNT_W(CW)) dut (
        .clk                         (clk),
        .rst                         (rst),
        .i_ram_data                  (i_ram_data),
        .i_alu_result                (i_alu_result),
        .i_inst_mux_br_write_address (i_wa),
        .i_regWrite                  (i_we),
        .i_memToReg                  (i_mtr),
        .i_read_addr1                (i_ra1),
        .i_read_addr2                (i_ra2),
        .o_read_data1                (o_rd1),
        .o_read_data2                (o_rd2),
        .o_wb_data                   (o_wb_data),
        .o_wb_count                  (o_wb_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_wb();
        return i_mtr ? i_ram_data : i_alu_result;
    endfunction

    function automatic logic [31:0] exp_read(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (!rst && i_we && i_wa == a) return exp_wb();
        return m_regs[a];
    endfunction

    // One clock: drive, check combinational outputs against the model, take the edge, update the model.
    task automatic cyc(input logic r, input logic we, input logic mtr, input logic [4:0] wa,
                       input logic [31:0] ram, input logic [31:0] alu,
                       input logic [4:0] ra1, input logic [4:0] ra2);
        rst = r; i_we = we; i_mtr = mtr; i_wa = wa;
        i_ram_data = ram; i_alu_result = alu; i_ra1 = ra1; i_ra2 = ra2;
        #1;
        check("wb_data", o_wb_data, exp_wb());
        check("read1", o_rd1, exp_read(ra1));
        check("read2", o_rd2, exp_read(ra2));
        check("count", 32'(o_wb_count), m_cnt);
        @(posedge clk);
        if (r) begin
            foreach (m_regs[i]) m_regs[i] = 32'h0;
            m_cnt = 0;
        end else if (we && wa != 5'd0) begin
            m_regs[wa] = mtr ? ram : alu;
            m_cnt = (m_cnt + 1) % (2 ** CW);
        end
        @(negedge clk);
    endtask

    task automatic rand_cyc(input logic r);
        logic [4:0] wa, ra1, ra2;
        wa  = 5'($urandom_range(0, 31));
        ra1 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
        ra2 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
        cyc(r, 1'($urandom), 1'($urandom), wa, $urandom, $urandom, ra1, ra2);
    endtask

    initial begin
        logic [31:0] r10;
        foreach (m_regs[i]) m_regs[i] = 32'h0;
        m_cnt = 0;
        rst = 1'b1; i_we = 1'b0; i_mtr = 1'b0; i_wa = '0;
        i_ram_data = '0; i_alu_result = '0; i_ra1 = '0; i_ra2 = '0;
        @(negedge clk);
        @(negedge clk);

        for (int i = 0; i < 20; i++) rand_cyc(1'b0);
        rand_cyc(1'b1);
        rand_cyc(1'b1);
        // Still in reset, writes to the very address being read must not bypass.
        for (int a = 0; a < 32; a++) begin
            cyc(1'b1, 1'b1, 1'b0, 5'(a), 32'hCAFE0000, 32'hBAD00000 + 32'(a), 5'(a), 5'(31 - a));
            check("reset_read", o_rd1, 32'h0);
        end
        check("reset_count", 32'(o_wb_count), 32'h0);

        cyc(1'b0, 1'b1, 1'b0, 5'd8, 32'h0, 32'h0000002A, 5'd0, 5'd0);
        cyc(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd8, 5'd0);
        check("alu_wb_read", o_rd1, 32'h0000002A);
        check("alu_wb_count", 32'(o_wb_count), 32'd1);

        i_ra1 = 5'd9; i_ra2 = 5'd9;
        rst = 1'b0; i_we = 1'b1; i_mtr = 1'b1; i_wa = 5'd9;
        i_ram_data = 32'hDEADBEEF; i_alu_result = 32'h0;
        #1;
        check("bypass_rd1", o_rd1, 32'hDEADBEEF);
        check("bypass_rd2", o_rd2, 32'hDEADBEEF);
        @(negedge clk);
        m_regs[9] = 32'hDEADBEEF;
        m_cnt = m_cnt + 1;
        cyc(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd9, 5'd9);
        check("load_after_rd1", o_rd1, 32'hDEADBEEF);
        check("load_after_rd2", o_rd2, 32'hDEADBEEF);

        cyc(1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 32'hFFFFFFFF, 5'd0, 5'd0);
        check("r0_same", o_rd1, 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0);
        check("r0_next", o_rd2, 32'h0);
        check("r0_count", 32'(o_wb_count), 32'd2);

        cyc(1'b0, 1'b1, 1'b0, 5'd10, 32'h0, 32'h0000A5A5, 5'd0, 5'd0);
        cyc(1'b0, 1'b0, 1'b1, 5'd10, 32'h12345678, 32'h0, 5'd10, 5'd10);
        check("wdis_wbdata", o_wb_data, 32'h12345678);
        r10 = o_rd1;
        check("wdis_nobypass", r10, 32'h0000A5A5);
        cyc(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd10, 5'd0);
        check("wdis_kept", o_rd1, 32'h0000A5A5);
        check("wdis_count", 32'(o_wb_count), 32'd3);

        for (int i = 0; i < 300; i++) rand_cyc($urandom_range(0, 19) == 0);

        cyc(1'b0, 1'b1, 1'b0, 5'd5, 32'h0, 32'h00000077, 5'd0, 5'd0);
        cyc(1'b1, 1'b1, 1'b0, 5'd5, 32'h0, 32'h00000055, 5'd5, 5'd5);
        cyc(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd5, 5'd0);
        check("rst_collide_r5", o_rd1, 32'h0);
        check("rst_collide_cnt", 32'(o_wb_count), 32'h0);

        for (int i = 0; i < (2 ** CW) - 2; i++)
            cyc(1'b0, 1'b1, 1'b0, 5'(1 + (i % 31)), 32'h0, $urandom, 5'(1 + (i % 31)), 5'd0);
        check("cnt_max", 32'(o_wb_count), 32'((2 ** CW) - 2));
        cyc(1'b0, 1'b1, 1'b1, 5'd3, $urandom, 32'h0, 5'd3, 5'd3);
        check("cnt_allones", 32'(o_wb_count), 32'((2 ** CW) - 1));
        cyc(1'b0, 1'b1, 1'b0, 5'd4, 32'h0, 32'h44, 5'd4, 5'd0);
        cyc(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd4, 5'd0);
        check("cnt_wrap", 32'(o_wb_count), 32'h0);
        check("wrap_write", o_rd1, 32'h44);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench exceeded its time limit");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
Writeback-stage consumer of the MEM/WB pipeline register outputs. It selects the writeback value (RAM data or ALU result), commits it to a 32 x 32 register file, and serves two combinational read ports to the decode stage. Write-through bypass resolves same-cycle WB/ID collisions. A retired-write counter supports debug.

Parameters:
DATA_W, 32, register and datapath width
ADDR_W, 5, register address width (2**ADDR_W registers)
CNT_W, 32, width of retired-write counter

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  synchronous, active-high reset
i_ram_data  input  DATA_W  load data from the MEM/WB buffer
i_alu_result  input  DATA_W  ALU result from the MEM/WB buffer
i_inst_mux_br_write_address  input  ADDR_W  destination register
i_regWrite  input  1  write enable from the MEM/WB buffer
i_memToReg  input  1  1 = write i_ram_data; 0 = write i_alu_result
i_read_addr1  input  ADDR_W  read port 1 address (rs)
i_read_addr2  input  ADDR_W  read port 2 address (rt)
o_read_data1  output  DATA_W  read port 1 data, combinational
o_read_data2  output  DATA_W  read port 2 data, combinational
o_wb_data  output  DATA_W  selected writeback value, combinational
o_wb_count  output  CNT_W  count of committed register writes

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset: on a posedge with rst=1, all 32 registers load 0 and o_wb_count loads 0. Any write presented in that cycle is dropped. rst has priority over all other inputs.
- Writeback mux: o_wb_data = i_memToReg ? i_ram_data : i_alu_result. The mux is always active, independent of i_regWrite.
- Write commit condition: rst=0, i_regWrite=1 and i_inst_mux_br_write_address != 0.
  - When the condition holds, register[addr] <= o_wb_data at posedge (1-cycle write latency).
  - o_wb_count increments by 1 in the same cycle.
- Register 0:
  - Always reads 0.
  - A write to address 0 is not committed and does not increment the counter.
- Read ports are combinational:
  - If addr == 0, output 0.
  - Else if a write-commit condition holds this cycle for the same address, output o_wb_data (write-through bypass).
  - Else output the stored register value.
- While rst=1, the bypass is disabled. Reads return the stored array contents, which are all 0 from the second reset cycle onward.
- Both read ports may address the same register, including the one being written; both return identical data.
- Counter: unsigned, wraps from 2**CNT_W-1 to 0 with no flag.
- No stall or handshake. The block accepts one writeback per cycle, every cycle. An X on i_regWrite is a protocol violation and is not checked.
- Reset mid-operation: a write asserted in the same cycle as rst is lost. A write in the cycle after rst deasserts commits normally.

Decomposition:
- Shared package mips_pkg: REG_ZERO = 5'd0, DATA_W/ADDR_W defaults, and a wb_sel_t enum (WB_ALU=0, WB_MEM=1) matching i_memToReg encoding.
- One natural sub-module: wb_mux (2:1 writeback select, combinational). It is reused by any future forwarding unit that needs the WB-stage value.
- The register array and bypass logic stay in wb_regfile.

Test Plan:
- Reset: hold rst=1 for 2 cycles after random writes -> all 32 reads return 0x00000000; o_wb_count = 0.
- ALU writeback: i_regWrite=1, i_memToReg=0, addr=8, i_alu_result=0x0000002A -> next cycle read_addr1=8 returns 0x2A; o_wb_count = 1.
- Load writeback with bypass: i_regWrite=1, i_memToReg=1, addr=9, i_ram_data=0xDEADBEEF, with read_addr1=read_addr2=9 in the same cycle -> both reads return 0xDEADBEEF before the edge and after it.
- Register 0 protection: i_regWrite=1, addr=0, i_alu_result=0xFFFFFFFF -> read of 0 returns 0 in the same cycle and the next; o_wb_count unchanged.
- Write disabled: i_regWrite=0, addr=10, data=0x12345678 -> register 10 keeps its prior value; no bypass; count unchanged. o_wb_data still shows 0x12345678 when i_memToReg selects it.
- Reset collision and wrap: assert rst with i_regWrite=1, addr=5, data=0x55 -> register 5 = 0. Then preload o_wb_count to 0xFFFFFFFF via 2**32-1 writes (or force in sim) and do one write -> count = 0.
